// File: rtl/adc_avg_filter.sv
// adc_avg_filter: boxcar moving average over the last 2^LOG2_DEPTH ADC samples.
// Define ADC_AVG_ROUND_EN for round-half-up output; default build truncates.
module adc_avg_filter #(
  parameter int WIDTH      = 12,
  parameter int LOG2_DEPTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sample_in,
  input  logic             sample_valid,
  output logic [WIDTH-1:0] avg_out,
  output logic             avg_valid,
  output logic             buf_full
);
  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam int SW    = WIDTH + LOG2_DEPTH;

  typedef enum logic {ST_FILL = 1'b0, ST_RUN = 1'b1} state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [WIDTH-1:0]      r_entry [DEPTH];
  logic [LOG2_DEPTH-1:0] r_wr_ptr;
  logic [LOG2_DEPTH-1:0] r_fill_cnt;
  logic [SW-1:0]         r_sum;
  logic [SW-1:0]         w_sum_next;
  logic [WIDTH-1:0]      r_avg;
  logic                  r_avg_valid;
  logic                  r_buf_full;
  logic                  w_fill_done;
  logic                  w_avg_load;
  logic [WIDTH-1:0]      w_avg_new;

  // Oldest entry is zero while filling, so one update rule covers both states.
  assign w_sum_next = r_sum + SW'(sample_in) - SW'(r_entry[r_wr_ptr]);

`ifdef ADC_AVG_ROUND_EN
  // Adding half an LSB before the shift equals adding the bit just below the cut.
  logic [WIDTH:0] w_avg_rnd;
  assign w_avg_rnd = {1'b0, w_sum_next[SW-1:LOG2_DEPTH]} + (WIDTH+1)'(w_sum_next[LOG2_DEPTH-1]);
  assign w_avg_new = w_avg_rnd[WIDTH] ? '1 : w_avg_rnd[WIDTH-1:0];
`else
  assign w_avg_new = w_sum_next[SW-1:LOG2_DEPTH];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_FILL;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (r_state == ST_FILL && sample_valid && r_fill_cnt == LOG2_DEPTH'(DEPTH-1))
      w_state_next = ST_RUN;
  end

  always_comb begin
    w_fill_done = 1'b0;
    w_avg_load  = 1'b0;
    if (r_state == ST_FILL && w_state_next == ST_RUN) w_fill_done = 1'b1;
    if (sample_valid && w_state_next == ST_RUN)       w_avg_load  = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_entry[i] <= '0;
      r_wr_ptr    <= '0;
      r_fill_cnt  <= '0;
      r_sum       <= '0;
      r_avg       <= '0;
      r_avg_valid <= 1'b0;
      r_buf_full  <= 1'b0;
    end else begin
      r_avg_valid <= w_avg_load;
      if (sample_valid) begin
        r_entry[r_wr_ptr] <= sample_in;
        r_wr_ptr          <= r_wr_ptr + LOG2_DEPTH'(1);
        r_sum             <= w_sum_next;
        if (r_state == ST_FILL) r_fill_cnt <= r_fill_cnt + LOG2_DEPTH'(1);
      end
      if (w_avg_load)  r_avg      <= w_avg_new;
      if (w_fill_done) r_buf_full <= 1'b1;
    end
  end

  assign avg_out   = r_avg;
  assign avg_valid = r_avg_valid;
  assign buf_full  = r_buf_full;
endmodule

// File: tb/tb_adc_avg_filter.sv
// tb_adc_avg_filter: randomized and directed checks of adc_avg_filter against a queue-based mean model.
// Honours ADC_AVG_ROUND_EN for the expected rounding mode.
module tb_adc_avg_filter;
  localparam int WIDTH = 12;
  localparam int DEPTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] sample_in;
  logic             sample_valid;
  logic [WIDTH-1:0] avg_out;
  logic             avg_valid;
  logic             buf_full;

  int checks   = 0;
  int failures = 0;

  int hist[$];
  int n_acc;
  int m_avg;

  always #5 clk = ~clk;

  adc_avg_filter #(.WIDTH(WIDTH), .LOG2_DEPTH(3)) dut (
    .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
    .avg_out(avg_out), .avg_valid(avg_valid), .buf_full(buf_full)
  );

  task automatic model_reset();
    hist.delete();
    n_acc = 0;
    m_avg = 0;
  endtask

  // Mean of the most recent DEPTH accepted samples, once DEPTH have arrived.
  task automatic model_push(input int v);
    int s;
    hist.push_back(v);
    if (hist.size() > DEPTH) void'(hist.pop_front());
    n_acc++;
    if (n_acc >= DEPTH) begin
      s = 0;
      foreach (hist[i]) s += hist[i];
`ifdef ADC_AVG_ROUND_EN
      m_avg = (s + DEPTH/2) / DEPTH;
      if (m_avg > 4095) m_avg = 4095;
`else
      m_avg = s / DEPTH;
`endif
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    sample_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // Drives one strobe; returns at the following falling edge, when its result is visible.
  task automatic send(input int v);
    @(negedge clk);
    sample_in = WIDTH'(v);
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    model_push(v);
  endtask

  task automatic test_reset();
    do_reset();
    for (int k = 0; k < DEPTH; k++) send(12'h123);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (avg_out !== 12'h000 || avg_valid !== 1'b0 || buf_full !== 1'b0) begin
      failures++;
      $display("FAIL reset_async got avg=%h v=%b full=%b exp avg=000 v=0 full=0", avg_out, avg_valid, buf_full);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    checks++;
    if (avg_out !== 12'h000 || avg_valid !== 1'b0 || buf_full !== 1'b0) begin
      failures++;
      $display("FAIL reset_release got avg=%h v=%b full=%b exp avg=000 v=0 full=0", avg_out, avg_valid, buf_full);
    end
  endtask

  task automatic test_fill();
    do_reset();
    for (int k = 1; k <= DEPTH; k++) begin
      send(12'h800);
      checks++;
      if (avg_valid !== (k == DEPTH) || buf_full !== (k == DEPTH)) begin
        failures++;
        $display("FAIL fill_flags k=%0d got v=%b full=%b exp=%b", k, avg_valid, buf_full, (k == DEPTH));
      end
    end
    checks++;
    if (avg_out !== 12'h800) begin
      failures++;
      $display("FAIL fill_avg got=%h exp=800", avg_out);
    end
    @(negedge clk);
    checks++;
    if (avg_valid !== 1'b0 || avg_out !== 12'h800 || buf_full !== 1'b1) begin
      failures++;
      $display("FAIL fill_hold got avg=%h v=%b full=%b exp avg=800 v=0 full=1", avg_out, avg_valid, buf_full);
    end
  endtask

  task automatic test_full_scale();
    int tbl[8] = '{12'h1FF, 12'h3FF, 12'h5FF, 12'h7FF, 12'h9FF, 12'hBFF, 12'hDFF, 12'hFFF};
    do_reset();
    for (int k = 0; k < DEPTH; k++) send(0);
    for (int k = 0; k < DEPTH; k++) begin
      send(12'hFFF);
      checks++;
      if (avg_valid !== 1'b1 || int'(avg_out) != m_avg) begin
        failures++;
        $display("FAIL full_scale k=%0d got avg=%h v=%b exp avg=%h v=1", k, avg_out, avg_valid, m_avg);
      end
`ifndef ADC_AVG_ROUND_EN
      checks++;
      if (int'(avg_out) != tbl[k]) begin
        failures++;
        $display("FAIL full_scale_tbl k=%0d got=%h exp=%h", k, avg_out, tbl[k]);
      end
`endif
    end
  endtask

  task automatic test_back_to_back();
    int  pulses = 0;
    bit  ev = 1'b0;
    int  ea = 0;
    do_reset();
    for (int i = 0; i <= 20; i++) begin
      @(negedge clk);
      if (i > 0) begin
        if (avg_valid === 1'b1) pulses++;
        checks++;
        if (avg_valid !== ev || (ev && int'(avg_out) != ea)) begin
          failures++;
          $display("FAIL b2b i=%0d got avg=%h v=%b exp avg=%h v=%b", i, avg_out, avg_valid, ea, ev);
        end
      end
      if (i < 20) begin
        sample_in = WIDTH'(i);
        sample_valid = 1'b1;
        model_push(i);
        ev = (n_acc >= DEPTH);
        ea = m_avg;
      end else begin
        sample_valid = 1'b0;
      end
    end
    checks++;
    if (pulses != 13) begin
      failures++;
      $display("FAIL b2b_pulses got=%0d exp=13", pulses);
    end
    checks++;
`ifdef ADC_AVG_ROUND_EN
    if (avg_out !== 12'h010) begin
      failures++;
      $display("FAIL b2b_last got=%h exp=010", avg_out);
    end
`else
    if (avg_out !== 12'h00F) begin
      failures++;
      $display("FAIL b2b_last got=%h exp=00f", avg_out);
    end
`endif
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int k = 0; k < 5; k++) send($urandom_range(0, 4095));
    do_reset();
    for (int k = 1; k <= DEPTH; k++) begin
      send($urandom_range(0, 4095));
      checks++;
      if (avg_valid !== (k == DEPTH) || buf_full !== (k == DEPTH)) begin
        failures++;
        $display("FAIL reset_mid k=%0d got v=%b full=%b exp=%b", k, avg_valid, buf_full, (k == DEPTH));
      end
    end
    checks++;
    if (int'(avg_out) != m_avg) begin
      failures++;
      $display("FAIL reset_mid_avg got=%h exp=%h", avg_out, m_avg);
    end
  endtask

  task automatic test_rounding();
    do_reset();
    for (int k = 0; k < DEPTH-1; k++) send(0);
    send(4);
    checks++;
`ifdef ADC_AVG_ROUND_EN
    if (avg_valid !== 1'b1 || avg_out !== 12'h001) begin
      failures++;
      $display("FAIL rounding got avg=%h v=%b exp avg=001 v=1", avg_out, avg_valid);
    end
`else
    if (avg_valid !== 1'b1 || avg_out !== 12'h000) begin
      failures++;
      $display("FAIL rounding got avg=%h v=%b exp avg=000 v=1", avg_out, avg_valid);
    end
`endif
  endtask

  task automatic test_random();
    int sent = 0;
    int gap  = 0;
    int v;
    int ea   = 0;
    bit ev   = 1'b0;
    bit ef   = 1'b0;
    do_reset();
    while (sent < 1000) begin
      @(negedge clk);
      checks++;
      if (avg_valid !== ev || int'(avg_out) != ea || buf_full !== ef) begin
        failures++;
        $display("FAIL random n=%0d got avg=%h v=%b full=%b exp avg=%h v=%b full=%b",
                 sent, avg_out, avg_valid, buf_full, ea, ev, ef);
      end
      if (gap == 0) begin
        v = $urandom_range(0, 4095);
        sample_in = WIDTH'(v);
        sample_valid = 1'b1;
        model_push(v);
        ev = (n_acc >= DEPTH);
        ef = ev;
        ea = m_avg;
        gap = $urandom_range(0, 50);
        sent++;
      end else begin
        sample_valid = 1'b0;
        ev = 1'b0;
        gap--;
      end
    end
    @(negedge clk);
    sample_valid = 1'b0;
    checks++;
    if (avg_valid !== ev || int'(avg_out) != ea || buf_full !== ef) begin
      failures++;
      $display("FAIL random_last got avg=%h v=%b full=%b exp avg=%h v=%b full=%b",
               avg_out, avg_valid, buf_full, ea, ev, ef);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    sample_in = '0;
    sample_valid = 1'b0;
    model_reset();
    test_reset();
    test_fill();
    test_full_scale();
    test_back_to_back();
    test_reset_mid();
    test_rounding();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
